// File: rtl/muldiv_hilo.sv
// muldiv_hilo: multiply/divide sequencer and HI/LO register file.
// Multiplies with an iterative shift-add engine. Divides by driving an
// external long_idiv divider, then captures its remainder/quotient into HI/LO.
module muldiv_hilo #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               op_valid,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               op_stall,
    output logic [WIDTH-1:0]   res,
    output logic               res_valid,
    output logic               busy,
    output logic [WIDTH-1:0]   div_dividend,
    output logic [WIDTH-1:0]   div_divider,
    output logic               div_signd,
    output logic               div_start,
    input  logic               div_ready,
    input  logic [2*WIDTH-1:0] div_remquot
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MFHI  = 3'd6;
    localparam logic [2:0] OP_MFLO  = 3'd7;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_MUL    = 3'd1;
    localparam logic [2:0] S_MFIN   = 3'd2;
    localparam logic [2:0] S_DSTART = 3'd3;
    localparam logic [2:0] S_DWAIT  = 3'd4;

    logic [2:0]         r_state;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_sign;
    logic [5:0]         r_count;
    logic [WIDTH-1:0]   r_div_dividend;
    logic [WIDTH-1:0]   r_div_divider;
    logic               r_div_signd;
    logic               r_div_start;

    logic               w_busy;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_neg_acc;

    assign w_busy       = (r_state != S_IDLE);
    assign busy         = w_busy;
    assign op_stall     = op_valid && w_busy;
    assign res_valid    = op_valid && !w_busy && ((op == OP_MFHI) || (op == OP_MFLO));
    assign res          = (op == OP_MFHI) ? r_hi : r_lo;
    assign div_dividend = r_div_dividend;
    assign div_divider  = r_div_divider;
    assign div_signd    = r_div_signd;
    assign div_start    = r_div_start;

    // Operand magnitudes for MULT, the partial-sum adder and the negated product.
    // The magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude, so no overflow handling is needed.
    always_comb begin
        w_abs_a   = op_a;
        w_abs_b   = op_b;
        if (op == OP_MULT) begin
            if (op_a[WIDTH-1]) w_abs_a = -op_a;
            if (op_b[WIDTH-1]) w_abs_b = -op_b;
        end
        w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                    {1'b0, (r_mplier[0] ? r_mcand : {WIDTH{1'b0}})};
        w_neg_acc = -r_acc;
    end

    // Sequencer: accepts ops in IDLE, runs the multiply loop, hands divides to
    // the divider and writes HI/LO; a synchronous reset aborts any operation.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state        <= S_IDLE;
            r_hi           <= '0;
            r_lo           <= '0;
            r_acc          <= '0;
            r_mcand        <= '0;
            r_mplier       <= '0;
            r_sign         <= 1'b0;
            r_count        <= '0;
            r_div_dividend <= '0;
            r_div_divider  <= '0;
            r_div_signd    <= 1'b0;
            r_div_start    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (op_valid) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                r_mcand  <= w_abs_a;
                                r_mplier <= w_abs_b;
                                r_sign   <= (op == OP_MULT) && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                                r_acc    <= '0;
                                r_count  <= 6'd32;
                                r_state  <= S_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_div_dividend <= op_a;
                                r_div_divider  <= op_b;
                                r_div_signd    <= (op == OP_DIV);
                                r_div_start    <= 1'b1;
                                r_state        <= S_DSTART;
                            end
                            OP_MTHI: r_hi <= op_a;
                            OP_MTLO: r_lo <= op_a;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count - 6'd1;
                    if (r_count == 6'd1) r_state <= S_MFIN;
                end
                S_MFIN: begin
                    {r_hi, r_lo} <= r_sign ? w_neg_acc : r_acc;
                    r_state      <= S_IDLE;
                end
                S_DSTART: begin
                    r_div_start <= 1'b0;
                    r_state     <= S_DWAIT;
                end
                S_DWAIT: begin
                    if (div_ready) begin
                        r_hi    <= div_remquot[2*WIDTH-1:WIDTH];
                        r_lo    <= div_remquot[WIDTH-1:0];
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
